mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/writeback
// steps for a small MIPS-like ISA, with a memory timeout and retire count.
// Ports: clk, rst (async active-low); opcode/funct/alu_zero/mem_ready in;
// ir_load, pc_en, pc_src, RegWrite, MemRead, MemWrite, AluOp, RegDst,
// AluSrc, MemToReg strobes; trap/trap_cause fault; retired counter.
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AluOp,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        MemToReg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  // Last wait value still allowed; one more idle cycle is a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        sub_q, sub_d;
  logic        is_r_q, is_r_d;
  logic        is_lw_q, is_lw_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] retired_q;
  logic        retire;

  logic dec_add, dec_sub, dec_addi;
  logic dec_lw, dec_sw, dec_beq, dec_j;

  assign dec_add  = (opcode == 6'h00) && (funct == 6'h20);
  assign dec_sub  = (opcode == 6'h00) && (funct == 6'h22);
  assign dec_addi = (opcode == 6'h08);
  assign dec_lw   = (opcode == 6'h23);
  assign dec_sw   = (opcode == 6'h2B);
  assign dec_beq  = (opcode == 6'h04);
  assign dec_j    = (opcode == 6'h02);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sub_q     <= 1'b0;
      is_r_q    <= 1'b0;
      is_lw_q   <= 1'b0;
      wait_q    <= 8'd0;
      cause_q   <= 2'b00;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      is_r_q  <= is_r_d;
      is_lw_q <= is_lw_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (retire)
        retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    is_r_d  = is_r_q;
    is_lw_d = is_lw_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        sub_d   = 1'b0;
        is_r_d  = 1'b0;
        is_lw_d = 1'b0;
        unique case (1'b1)
          dec_add: begin
            state_d = S_EXEC_R;
            is_r_d  = 1'b1;
          end
          dec_sub: begin
            state_d = S_EXEC_R;
            is_r_d  = 1'b1;
            sub_d   = 1'b1;
          end
          dec_addi: state_d = S_EXEC_I;
          dec_lw: begin
            state_d = S_MEM_ADDR;
            is_lw_d = 1'b1;
          end
          dec_sw:  state_d = S_MEM_ADDR;
          dec_beq: state_d = S_BRANCH;
          dec_j:   state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        wait_d  = 8'd0;
        state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          if (state_q == S_MEM_RD) begin
            state_d = S_MEM_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end
        end
      end
      S_MEM_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH, S_JUMP: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    pc_src   = 2'b00;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    AluOp    = 1'b0;
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemToReg = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_en   = 1'b1;
      end
      S_EXEC_R: begin
        RegDst = 1'b1;
        AluOp  = sub_q;
      end
      S_EXEC_I: AluSrc = 1'b1;
      S_WB_ALU: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        RegDst   = is_r_q;
        AluSrc   = !is_r_q;
        AluOp    = is_r_q && sub_q;
      end
      S_MEM_ADDR: AluSrc = 1'b1;
      S_MEM_RD: begin
        MemRead = 1'b1;
        AluSrc  = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        AluSrc   = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        AluSrc   = 1'b1;
      end
      S_BRANCH: begin
        AluOp  = 1'b1;
        pc_src = 2'b01;
        pc_en  = alu_zero;
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = 2'b10;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: instruction-level reference model
// producing expected per-cycle strobe vectors and retire counts.
module tb_mc_control;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ready;
  logic        ir_load, pc_en;
  logic [1:0]  pc_src;
  logic        RegWrite, MemRead, MemWrite;
  logic        AluOp, RegDst, AluSrc, MemToReg;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  mc_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .AluOp(AluOp), .RegDst(RegDst), .AluSrc(AluSrc),
    .MemToReg(MemToReg), .trap(trap), .trap_cause(trap_cause),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LW = 3;
  localparam int K_SW = 4, K_BEQ = 5, K_J = 6;
  localparam int K_ILL = 7, K_ILLF = 8;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret;
  logic [11:0] exp_q[$];
  logic        rdy_q[$];

  wire [11:0] outv = {ir_load, pc_en, pc_src, RegWrite, MemRead,
                      MemWrite, AluOp, RegDst, AluSrc, MemToReg, trap};

  function automatic logic [11:0] v(
    input logic il, input logic pe, input logic [1:0] ps,
    input logic rw, input logic mr, input logic mw, input logic ao,
    input logic rd, input logic as, input logic mtr, input logic tr);
    return {il, pe, ps, rw, mr, mw, ao, rd, as, mtr, tr};
  endfunction

  localparam logic [11:0] V_FETCH = 12'b1100_0000_0000;
  localparam logic [11:0] V_TRAP  = 12'b0000_0000_0001;

  function automatic void push(input logic [11:0] e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endfunction

  // Expected strobe vector for every cycle of one instruction,
  // FETCH first; the cycle after the last entry must be FETCH again.
  function automatic void build(input int kind, input int waits,
                                input logic zero);
    logic s;
    exp_q.delete();
    rdy_q.delete();
    push(V_FETCH, 1'b0);
    push(12'd0, 1'b0);
    s = (kind == K_SUB);
    case (kind)
      K_ADD, K_SUB: begin
        push(v(0,0,2'b00,0,0,0,s,1,0,0,0), 1'b0);
        push(v(0,0,2'b00,1,0,0,s,1,0,1,0), 1'b0);
      end
      K_ADDI: begin
        push(v(0,0,2'b00,0,0,0,0,0,1,0,0), 1'b0);
        push(v(0,0,2'b00,1,0,0,0,0,1,1,0), 1'b0);
      end
      K_LW: begin
        push(v(0,0,2'b00,0,0,0,0,0,1,0,0), 1'b0);
        for (int k = 0; k <= waits; k++)
          push(v(0,0,2'b00,0,1,0,0,0,1,0,0), k == waits);
        push(v(0,0,2'b00,1,0,0,0,0,1,0,0), 1'b0);
      end
      K_SW: begin
        push(v(0,0,2'b00,0,0,0,0,0,1,0,0), 1'b0);
        for (int k = 0; k <= waits; k++)
          push(v(0,0,2'b00,0,0,1,0,0,1,0,0), k == waits);
      end
      K_BEQ: push(v(0,zero,2'b01,0,0,0,1,0,0,0,0), 1'b0);
      K_J:   push(v(0,1,2'b10,0,0,0,0,0,0,0,0), 1'b0);
      default: ;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ret = 32'd0;
    step();
  endtask

  // Runs one instruction from a FETCH cycle. stop_at >= 0 leaves the
  // DUT in the state of that cycle index, without the retire check.
  task automatic run_instr(input int kind, input int waits,
                           input logic zero, input int stop_at);
    logic [5:0] op, fn;
    fn = 6'($urandom);
    case (kind)
      K_ADD:  begin op = 6'h00; fn = 6'h20; end
      K_SUB:  begin op = 6'h00; fn = 6'h22; end
      K_ADDI: op = 6'h08;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_ILL:  op = 6'h3F;
      default: begin op = 6'h00; fn = 6'h21; end
    endcase
    build(kind, waits, zero);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i <= 1) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      mem_ready = rdy_q[i];
      alu_zero  = (kind == K_BEQ) ? zero : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (outv !== exp_q[i]) begin
        errors++;
        $display("FAIL strobes kind=%0d cyc=%0d got=%b want=%b",
                 kind, i, outv, exp_q[i]);
      end
      if (i == stop_at) return;
      step();
    end
    mem_ready = 1'b0;
    exp_ret = exp_ret + 32'd1;
    #1;
    checks++;
    if (outv !== V_FETCH) begin
      errors++;
      $display("FAIL latency kind=%0d got=%b want=%b",
               kind, outv, V_FETCH);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL retired kind=%0d got=%h want=%h",
               kind, retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    alu_zero = 1'b0; mem_ready = 1'b0;
    exp_ret = 32'd0;
    #12;
    checks++;
    if (outv !== 12'd0 || retired !== 32'd0 || trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_vals got=%b/%h/%b want=0", outv, retired,
               trap_cause);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (outv !== 12'd0) begin
      errors++;
      $display("FAIL idle got=%b want=0", outv);
    end
    step();
    checks++;
    if (outv !== V_FETCH) begin
      errors++;
      $display("FAIL first_fetch got=%b want=%b", outv, V_FETCH);
    end
  endtask

  task automatic test_r_add();
    run_instr(K_ADD, 0, 1'b0, -1);
    checks++;
    if (retired !== 32'd1) begin
      errors++;
      $display("FAIL add_retired got=%h want=1", retired);
    end
    run_instr(K_SUB, 0, 1'b0, -1);
    run_instr(K_ADDI, 0, 1'b0, -1);
  endtask

  task automatic test_lw();
    run_instr(K_LW, 3, 1'b0, -1);
    run_instr(K_LW, 0, 1'b0, -1);
    run_instr(K_SW, 2, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(K_BEQ, 0, 1'b1, -1);
    run_instr(K_BEQ, 0, 1'b0, -1);
    run_instr(K_J, 0, 1'b0, -1);
  endtask

  task automatic test_timeout_edge();
    run_instr(K_SW, 15, 1'b0, -1);
    run_instr(K_LW, 15, 1'b0, -1);
  endtask

  task automatic test_timeout();
    logic [31:0] r0;
    r0 = exp_ret;
    run_instr(K_SW, 100, 1'b0, 3);
    mem_ready = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step();
      checks++;
      if (outv !== v(0,0,2'b00,0,0,1,0,0,1,0,0)) begin
        errors++;
        $display("FAIL sw_wait cyc=%0d got=%b", j + 2, outv);
      end
    end
    step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (outv !== V_TRAP || trap_cause !== 2'b10 || retired !== r0) begin
        errors++;
        $display("FAIL timeout_trap got=%b/%b/%h want=%b/10/%h",
                 outv, trap_cause, retired, V_TRAP, r0);
      end
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    mem_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_illegal(input int kind);
    run_instr(kind, 0, 1'b0, 1);
    step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (outv !== V_TRAP || trap_cause !== 2'b01) begin
        errors++;
        $display("FAIL illegal_trap kind=%0d got=%b/%b want=%b/01",
                 kind, outv, trap_cause, V_TRAP);
      end
      opcode = 6'($urandom);
      step();
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    run_instr(K_LW, 8, 1'b0, 4);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outv !== 12'd0 || retired !== 32'd0 || trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got=%b/%h/%b want=0", outv, retired,
               trap_cause);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ret = 32'd0;
    step();
    checks++;
    if (outv !== V_FETCH) begin
      errors++;
      $display("FAIL reset_refetch got=%b want=%b", outv, V_FETCH);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 6),
                1'($urandom_range(0, 1)), -1);
  endtask

  task automatic test_wrap();
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFE;
    run_instr(K_ADD, 0, 1'b0, -1);
    checks++;
    if (retired !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_max got=%h want=ffffffff", retired);
    end
    run_instr(K_ADDI, 0, 1'b0, -1);
    checks++;
    if (retired !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_zero got=%h want=0", retired);
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_lw();
    test_beq();
    test_timeout_edge();
    test_random();
    test_timeout();
    test_illegal(K_ILL);
    test_illegal(K_ILLF);
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
